// File: rtl/mem_stage.sv
// MEM stage of the 5-stage ARM pipeline: wait-stated data memory, MEM/WB register, ready/freeze handshake.
// Optional MEM-stage forwarding outputs are enabled by defining MEM_STAGE_FWD_EN.
module mem_stage #(
    parameter int MEM_WORDS   = 64,
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] ALU_result_in,
    input  logic [3:0]  wb_reg_dest_in,
    input  logic [31:0] val_rm_in,
`ifdef MEM_STAGE_FWD_EN
    output logic        fwd_wb_en,
    output logic [3:0]  fwd_dest,
    output logic [31:0] fwd_val,
`endif
    output logic        ready,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  wb_reg_dest_out
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] LO_ADDR = 33'(ADDR_BASE);
    localparam logic [32:0] HI_ADDR = 33'(ADDR_BASE) + 33'(4 * MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt, next_cnt;
    logic [31:0]       mem [MEM_WORDS];
    logic              req;
    logic              in_range;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_data;

    assign req      = mem_r_en_in | mem_w_en_in;
    assign in_range = ({1'b0, ALU_result_in} >= LO_ADDR) && ({1'b0, ALU_result_in} < HI_ADDR);
    assign offset   = ALU_result_in - 32'(ADDR_BASE);
    assign idx      = IDX_W'(offset >> 2);
    assign rd_data  = in_range ? mem[idx] : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // ready doubles as the commit strobe: it is high only on the edge where the access completes
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        ready      = 1'b1;
        case (state)
            IDLE: begin
                if (req && (WAIT_CYCLES > 0)) begin
                    ready      = 1'b0;
                    next_cnt   = CNT_LOAD;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    ready    = 1'b0;
                    next_cnt = cnt - 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (ready && mem_w_en_in && in_range) begin
            mem[idx] <= val_rm_in;
        end
    end

    // Stall edges load a bubble so WB never sees a half-finished access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out       <= 1'b0;
            mem_r_en_out    <= 1'b0;
            ALU_result_out  <= '0;
            mem_data_out    <= '0;
            wb_reg_dest_out <= '0;
        end else if (ready) begin
            wb_en_out       <= wb_en_in;
            mem_r_en_out    <= mem_r_en_in;
            ALU_result_out  <= ALU_result_in;
            mem_data_out    <= mem_r_en_in ? rd_data : 32'd0;
            wb_reg_dest_out <= wb_reg_dest_in;
        end else begin
            wb_en_out       <= 1'b0;
            mem_r_en_out    <= 1'b0;
            ALU_result_out  <= '0;
            mem_data_out    <= '0;
            wb_reg_dest_out <= '0;
        end
    end

`ifdef MEM_STAGE_FWD_EN
    // Load data is not available until the commit edge, so loads never forward from here
    assign fwd_wb_en = wb_en_in & ready & ~mem_r_en_in;
    assign fwd_dest  = wb_reg_dest_in;
    assign fwd_val   = ALU_result_in;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: one instance with 3 wait states, one with none.
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic stall_wb_seen;

    logic        wb_en3 = 0, r_en3 = 0, w_en3 = 0;
    logic [31:0] alu3 = 0, rm3 = 0;
    logic [3:0]  dest3 = 0;
    logic        ready3, wb_out3, r_out3;
    logic [31:0] alu_out3, data_out3;
    logic [3:0]  dest_out3;

    logic        wb_en0 = 0, r_en0 = 0, w_en0 = 0;
    logic [31:0] alu0 = 0, rm0 = 0;
    logic [3:0]  dest0 = 0;
    logic        ready0, wb_out0, r_out0;
    logic [31:0] alu_out0, data_out0;
    logic [3:0]  dest_out0;

`ifdef MEM_STAGE_FWD_EN
    logic        fwd_en3, fwd_en0;
    logic [3:0]  fwd_dest3, fwd_dest0;
    logic [31:0] fwd_val3, fwd_val0;
`endif

    always #5 clk = ~clk;

    mem_stage #(.MEM_WORDS(64), .ADDR_BASE(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en3), .mem_r_en_in(r_en3), .mem_w_en_in(w_en3),
        .ALU_result_in(alu3), .wb_reg_dest_in(dest3), .val_rm_in(rm3),
`ifdef MEM_STAGE_FWD_EN
        .fwd_wb_en(fwd_en3), .fwd_dest(fwd_dest3), .fwd_val(fwd_val3),
`endif
        .ready(ready3), .wb_en_out(wb_out3), .mem_r_en_out(r_out3),
        .ALU_result_out(alu_out3), .mem_data_out(data_out3), .wb_reg_dest_out(dest_out3)
    );

    mem_stage #(.MEM_WORDS(64), .ADDR_BASE(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en0), .mem_r_en_in(r_en0), .mem_w_en_in(w_en0),
        .ALU_result_in(alu0), .wb_reg_dest_in(dest0), .val_rm_in(rm0),
`ifdef MEM_STAGE_FWD_EN
        .fwd_wb_en(fwd_en0), .fwd_dest(fwd_dest0), .fwd_val(fwd_val0),
`endif
        .ready(ready0), .wb_en_out(wb_out0), .mem_r_en_out(r_out0),
        .ALU_result_out(alu_out0), .mem_data_out(data_out0), .wb_reg_dest_out(dest_out0)
    );

    // Drive one access into the 3-wait-state DUT and return once its commit edge has passed
    task automatic access3(input logic wb, input logic r, input logic w, input logic [31:0] addr,
                           input logic [3:0] dest, input logic [31:0] data, output int stalls);
        @(negedge clk);
        wb_en3 = wb; r_en3 = r; w_en3 = w; alu3 = addr; dest3 = dest; rm3 = data;
        stalls = 0;
        #1;
        while (ready3 !== 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            stall_wb_seen = stall_wb_seen | (wb_out3 !== 1'b0);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle3();
        @(negedge clk);
        wb_en3 = 0; r_en3 = 0; w_en3 = 0; alu3 = 0; dest3 = 0; rm3 = 0;
    endtask

    task automatic test_reset();
        int stalls;
        #1;
        checks++; if ({wb_out3, r_out3, alu_out3, data_out3, dest_out3} !== '0) begin errors++; $display("FAIL reset_outs_w3 got %h expected 0", {wb_out3, r_out3, alu_out3, data_out3, dest_out3}); end
        checks++; if ({wb_out0, r_out0, alu_out0, data_out0, dest_out0} !== '0) begin errors++; $display("FAIL reset_outs_w0 got %h expected 0", {wb_out0, r_out0, alu_out0, data_out0, dest_out0}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        w_en3 = 1; alu3 = 32'd1024; rm3 = 32'h1111_1111; wb_en3 = 1; dest3 = 4'd2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({wb_out3, r_out3, alu_out3, data_out3, dest_out3} !== '0) begin errors++; $display("FAIL reset_midwait_outs got %h expected 0", {wb_out3, r_out3, alu_out3, data_out3, dest_out3}); end
        wb_en3 = 0; r_en3 = 0; w_en3 = 0; alu3 = 0; dest3 = 0; rm3 = 0;
        #1;
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL reset_state_idle ready got %b expected 1", ready3); end
        @(negedge clk);
        rst = 1'b1;
        access3(1, 1, 0, 32'd1024, 4'd1, 0, stalls);
        checks++; if (data_out3 !== 32'd0) begin errors++; $display("FAIL reset_no_write got %h expected 0", data_out3); end
        checks++; if (stalls !== 3) begin errors++; $display("FAIL reset_load_stalls got %0d expected 3", stalls); end
    endtask

    task automatic test_store_load();
        int stalls;
        access3(0, 0, 1, 32'd1028, 4'd0, 32'hDEAD_BEEF, stalls);
        checks++; if (stalls !== 3) begin errors++; $display("FAIL store_stalls got %0d expected 3", stalls); end
        checks++; if ({wb_out3, r_out3, data_out3} !== 34'd0) begin errors++; $display("FAIL store_outs got %h expected 0", {wb_out3, r_out3, data_out3}); end
        access3(1, 1, 0, 32'd1028, 4'd5, 0, stalls);
        checks++; if (stalls !== 3) begin errors++; $display("FAIL load_stalls got %0d expected 3", stalls); end
        checks++; if (data_out3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data got %h expected deadbeef", data_out3); end
        checks++; if (r_out3 !== 1'b1) begin errors++; $display("FAIL load_r_en_out got %b expected 1", r_out3); end
        checks++; if (dest_out3 !== 4'd5) begin errors++; $display("FAIL load_dest got %0d expected 5", dest_out3); end
        checks++; if (alu_out3 !== 32'd1028) begin errors++; $display("FAIL load_alu got %0d expected 1028", alu_out3); end
    endtask

    task automatic test_non_mem();
        int stalls;
        stall_wb_seen = 1'b0;
        access3(1, 0, 1, 32'd1036, 4'd6, 32'h0000_0001, stalls);
        checks++; if (stall_wb_seen !== 1'b0) begin errors++; $display("FAIL stall_bubble wb_en_out seen %b expected 0", stall_wb_seen); end
        access3(1, 0, 0, 32'h55, 4'd7, 0, stalls);
        checks++; if (stalls !== 0) begin errors++; $display("FAIL nonmem_stalls got %0d expected 0", stalls); end
        checks++; if ({wb_out3, r_out3, alu_out3, dest_out3, data_out3} !== {1'b1, 1'b0, 32'h55, 4'd7, 32'd0}) begin
            errors++; $display("FAIL nonmem_outs got %h expected %h", {wb_out3, r_out3, alu_out3, dest_out3, data_out3}, {1'b1, 1'b0, 32'h55, 4'd7, 32'd0});
        end
    endtask

    task automatic test_out_of_range();
        int stalls;
        access3(0, 0, 1, 32'd1280, 4'd0, 32'h1234, stalls);
        checks++; if (stalls !== 3) begin errors++; $display("FAIL oor_store_stalls got %0d expected 3", stalls); end
        access3(1, 1, 0, 32'd1280, 4'd3, 0, stalls);
        checks++; if (data_out3 !== 32'd0) begin errors++; $display("FAIL oor_load got %h expected 0", data_out3); end
        access3(1, 1, 0, 32'd1024, 4'd3, 0, stalls);
        checks++; if (data_out3 !== 32'd0) begin errors++; $display("FAIL oor_word0 got %h expected 0", data_out3); end
        access3(1, 1, 0, 32'd1276, 4'd3, 0, stalls);
        checks++; if (data_out3 !== 32'd0) begin errors++; $display("FAIL oor_word63 got %h expected 0", data_out3); end
        access3(1, 1, 0, 32'd1029, 4'd3, 0, stalls);
        checks++; if (data_out3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_word1_kept got %h expected deadbeef", data_out3); end
        access3(1, 1, 0, 32'd1036, 4'd3, 0, stalls);
        checks++; if (data_out3 !== 32'h1) begin errors++; $display("FAIL word3_kept got %h expected 1", data_out3); end
    endtask

    task automatic test_read_write_same();
        int stalls;
        access3(0, 0, 1, 32'd1040, 4'd0, 32'h77, stalls);
        access3(1, 1, 1, 32'd1040, 4'd8, 32'h88, stalls);
        checks++; if (data_out3 !== 32'h77) begin errors++; $display("FAIL rw_old_data got %h expected 77", data_out3); end
        access3(1, 1, 0, 32'd1040, 4'd8, 0, stalls);
        checks++; if (data_out3 !== 32'h88) begin errors++; $display("FAIL rw_new_data got %h expected 88", data_out3); end
        idle3();
    endtask

    task automatic test_back_to_back();
        int low_count = 0;
        @(negedge clk);
        w_en0 = 1; r_en0 = 0; wb_en0 = 0; alu0 = 32'd1032; rm0 = 32'hA5A5_A5A5; dest0 = 0;
        #1; if (ready0 !== 1'b1) low_count++;
        @(negedge clk);
        w_en0 = 0; r_en0 = 1; wb_en0 = 1; alu0 = 32'd1032; rm0 = 0; dest0 = 4'd9;
        #1; if (ready0 !== 1'b1) low_count++;
        @(posedge clk);
        #1;
        checks++; if (data_out0 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL w0_load_data got %h expected a5a5a5a5", data_out0); end
        checks++; if ({r_out0, wb_out0, dest_out0} !== {1'b1, 1'b1, 4'd9}) begin errors++; $display("FAIL w0_load_flags got %h expected %h", {r_out0, wb_out0, dest_out0}, {1'b1, 1'b1, 4'd9}); end
        checks++; if (low_count !== 0) begin errors++; $display("FAIL w0_ready_low got %0d low cycles expected 0", low_count); end
    endtask

`ifdef MEM_STAGE_FWD_EN
    task automatic test_forward();
        @(negedge clk);
        w_en0 = 0; r_en0 = 0; wb_en0 = 1; alu0 = 32'h10; dest0 = 4'd3;
        #1;
        checks++; if ({fwd_en0, fwd_dest0, fwd_val0} !== {1'b1, 4'd3, 32'h10}) begin errors++; $display("FAIL fwd_alu got %h expected %h", {fwd_en0, fwd_dest0, fwd_val0}, {1'b1, 4'd3, 32'h10}); end
        @(negedge clk);
        r_en0 = 1; alu0 = 32'd1032;
        #1;
        checks++; if (fwd_en0 !== 1'b0) begin errors++; $display("FAIL fwd_load got %b expected 0", fwd_en0); end
        @(negedge clk);
        r_en0 = 0; wb_en0 = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stall_wb_seen = 1'b0;
        test_reset();
        test_store_load();
        test_non_mem();
        test_out_of_range();
        test_read_write_same();
        test_back_to_back();
`ifdef MEM_STAGE_FWD_EN
        test_forward();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
